// File: rtl/tamanho_pkg.sv
// tamanho_pkg: shared widths, FSM states and the canonical square-size table
package tamanho_pkg;
    localparam int SIZE_W = 10;
    localparam int CODE_W = 6;
    localparam int DEPTH = 1 << CODE_W;
    typedef enum logic [1:0] {IDLE, SCAN, DONE} estado_t;
    // Not monotonic: codes 60 and 61 repeat the sizes of codes 38 and 5
    localparam logic [SIZE_W-1:0] SIZE_TABLE [0:DEPTH-1] = '{
        10'd8,    10'd10,   10'd12,   10'd14,   10'd16,   10'd20,   10'd24,   10'd28,
        10'd32,   10'd36,   10'd40,   10'd48,   10'd56,   10'd64,   10'd72,   10'd80,
        10'd96,   10'd112,  10'd128,  10'd144,  10'd160,  10'd176,  10'd192,  10'd208,
        10'd224,  10'd240,  10'd256,  10'd288,  10'd320,  10'd352,  10'd384,  10'd416,
        10'd448,  10'd480,  10'd512,  10'd544,  10'd576,  10'd608,  10'd640,  10'd672,
        10'd704,  10'd736,  10'd768,  10'd800,  10'd832,  10'd864,  10'd896,  10'd928,
        10'd960,  10'd976,  10'd992,  10'd1000, 10'd1004, 10'd1008, 10'd1012, 10'd1016,
        10'd1018, 10'd1020, 10'd1022, 10'd1021, 10'd640,  10'd20,   10'd1019, 10'd100
    };
endpackage

// File: rtl/tamanho_tabela.sv
// tamanho_tabela: combinational code-to-size ROM over the canonical table
module tamanho_tabela
    import tamanho_pkg::*;
(
    input  logic [CODE_W-1:0] idx,
    output logic [SIZE_W-1:0] size
);
    assign size = SIZE_TABLE[idx];
endmodule

// File: rtl/tamanho_codificador.sv
// tamanho_codificador: linear search of the size table for the exact or largest-not-exceeding code
module tamanho_codificador #(
    parameter int SIZE_W = 10,
    parameter int CODE_W = 6,
    parameter int EARLY_EXIT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [SIZE_W-1:0] req_size,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [CODE_W-1:0] rsp_code,
    output logic              rsp_exact,
    output logic              rsp_none,
    output logic              busy
);
    import tamanho_pkg::*;
    estado_t state, next_state;
    logic [SIZE_W-1:0] req_q, entry_q, best_size, entry;
    logic [CODE_W-1:0] idx, best_code, exact_code, addr;
    logic primed, found, exact, hit, last;
    // The table read is registered: entry_q holds SIZE_TABLE[idx] once primed
    assign addr = primed ? idx + 1'b1 : idx;
    assign hit = primed && entry_q == req_q;
    assign last = primed && (idx == '1 || (EARLY_EXIT != 0 && hit));
    tamanho_tabela u_tabela (
        .idx  (addr),
        .size (entry)
    );
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= next_state;
    end
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = req_valid ? SCAN : IDLE;
            SCAN:    next_state = last ? DONE : SCAN;
            DONE:    next_state = rsp_ready ? IDLE : DONE;
            default: next_state = IDLE;
        endcase
        req_ready = state == IDLE;
        busy = state == SCAN;
        rsp_valid = state == DONE;
        rsp_code = rsp_valid ? (exact ? exact_code : best_code) : '0;
        rsp_exact = rsp_valid && exact;
        rsp_none = rsp_valid && !exact && !found;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            idx <= '0;
            primed <= 1'b0;
            req_q <= '0;
            entry_q <= '0;
            best_size <= '0;
            best_code <= '0;
            exact_code <= '0;
            found <= 1'b0;
            exact <= 1'b0;
        end else if (state == IDLE && req_valid) begin
            req_q <= req_size;
            idx <= '0;
            primed <= 1'b0;
            best_size <= '0;
            best_code <= '0;
            exact_code <= '0;
            found <= 1'b0;
            exact <= 1'b0;
        end else if (state == SCAN) begin
            entry_q <= entry;
            primed <= 1'b1;
            if (primed && !last) idx <= idx + 1'b1;
            if (hit && !exact) begin
                exact <= 1'b1;
                exact_code <= idx;
            end
            // Strict compare keeps the lowest code among equal candidates
            if (primed && entry_q < req_q && (!found || entry_q > best_size)) begin
                best_size <= entry_q;
                best_code <= idx;
                found <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_tamanho_codificador.sv
// tb_tamanho_codificador: randomized and directed checks against a two-pass table search model
module tb_tamanho_codificador;
    localparam int EE = 1;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic req_valid = 1'b0;
    logic req_ready;
    logic [9:0] req_size = '0;
    logic rsp_valid;
    logic rsp_ready = 1'b0;
    logic [5:0] rsp_code;
    logic rsp_exact, rsp_none, busy;
    int passed = 0;
    int total = 0;

    always #5 clk = ~clk;

    tamanho_codificador #(.SIZE_W(10), .CODE_W(6), .EARLY_EXIT(EE)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_size  (req_size),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_code  (rsp_code),
        .rsp_exact (rsp_exact),
        .rsp_none  (rsp_none),
        .busy      (busy)
    );

    // Pass 1: lowest exact code; pass 2: lowest code of the largest size below the request
    function automatic void model(input logic [9:0] r, output logic [5:0] c, output logic e,
                                  output logic n, output int lat);
        int best = -1;
        e = 1'b0;
        n = 1'b0;
        c = '0;
        for (int k = 0; k < 64; k++)
            if (!e && tamanho_pkg::SIZE_TABLE[k] == r) begin
                e = 1'b1;
                c = 6'(k);
            end
        if (!e) begin
            for (int k = 0; k < 64; k++)
                if (tamanho_pkg::SIZE_TABLE[k] < r &&
                    (best < 0 || tamanho_pkg::SIZE_TABLE[k] > tamanho_pkg::SIZE_TABLE[best]))
                    best = k;
            if (best < 0) n = 1'b1;
            else c = 6'(best);
        end
        lat = (EE != 0 && e) ? int'(c) + 2 : 65;
    endfunction

    task automatic do_req(input logic [9:0] s, output logic [5:0] c, output logic e,
                          output logic n, output int lat);
        req_valid = 1'b1;
        req_size = s;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_size = 10'($urandom);
        lat = 0;
        while (!rsp_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        c = rsp_code;
        e = rsp_exact;
        n = rsp_none;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic check_req(input logic [9:0] s, input string tag);
        logic [5:0] c, mc;
        logic e, n, me, mn;
        int lat, ml;
        model(s, mc, me, mn, ml);
        do_req(s, c, e, n, lat);
        total += 4;
        if (c !== mc) $display("FAIL %s code req=%0d got %0d want %0d", tag, s, c, mc); else passed++;
        if (e !== me) $display("FAIL %s exact req=%0d got %0b want %0b", tag, s, e, me); else passed++;
        if (n !== mn) $display("FAIL %s none req=%0d got %0b want %0b", tag, s, n, mn); else passed++;
        if (lat != ml) $display("FAIL %s latency req=%0d got %0d want %0d", tag, s, lat, ml); else passed++;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        total += 6;
        if (req_ready !== 1'b1) $display("FAIL reset req_ready got %b want 1", req_ready); else passed++;
        if (rsp_valid !== 1'b0) $display("FAIL reset rsp_valid got %b want 0", rsp_valid); else passed++;
        if (rsp_code !== 6'd0) $display("FAIL reset rsp_code got %0d want 0", rsp_code); else passed++;
        if (rsp_exact !== 1'b0) $display("FAIL reset rsp_exact got %b want 0", rsp_exact); else passed++;
        if (rsp_none !== 1'b0) $display("FAIL reset rsp_none got %b want 0", rsp_none); else passed++;
        if (busy !== 1'b0) $display("FAIL reset busy got %b want 0", busy); else passed++;
    endtask

    task automatic test_exact_all;
        for (int k = 0; k < 64; k++) check_req(tamanho_pkg::SIZE_TABLE[k], "exact");
    endtask

    task automatic test_bounds;
        check_req(10'd1023, "max");
        check_req(10'd0, "below_min");
        check_req(10'd7, "below_min");
        check_req(10'd9, "between");
        check_req(10'd641, "between");
    endtask

    task automatic test_random;
        for (int i = 0; i < 40; i++) check_req(10'($urandom_range(0, 1023)), "random");
    endtask

    task automatic test_backpressure;
        logic [5:0] mc;
        logic me, mn;
        int ml, w;
        model(10'd300, mc, me, mn, ml);
        req_valid = 1'b1;
        req_size = 10'd300;
        @(posedge clk); #1;
        req_valid = 1'b0;
        w = 0;
        while (!rsp_valid && w < 200) begin
            @(posedge clk); #1;
            w++;
        end
        for (int i = 0; i < 20; i++) begin
            total += 4;
            if (rsp_valid !== 1'b1) $display("FAIL bp valid cyc=%0d got %b want 1", i, rsp_valid); else passed++;
            if (rsp_code !== mc) $display("FAIL bp code cyc=%0d got %0d want %0d", i, rsp_code, mc); else passed++;
            if (rsp_exact !== me || rsp_none !== mn)
                $display("FAIL bp flags cyc=%0d got %b%b want %b%b", i, rsp_exact, rsp_none, me, mn);
            else passed++;
            if (req_ready !== 1'b0) $display("FAIL bp req_ready cyc=%0d got %b want 0", i, req_ready); else passed++;
            req_valid = (i == 5);
            req_size = 10'd20;
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        total += 2;
        if (rsp_valid !== 1'b0) $display("FAIL bp release valid got %b want 0", rsp_valid); else passed++;
        if (req_ready !== 1'b1) $display("FAIL bp release req_ready got %b want 1", req_ready); else passed++;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0)
            $display("FAIL bp ignored_pulse busy/valid got %b%b want 00", busy, rsp_valid);
        else passed++;
    endtask

    task automatic test_reset_mid;
        req_valid = 1'b1;
        req_size = 10'd1023;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        total += 3;
        if (busy !== 1'b0) $display("FAIL midrst busy got %b want 0", busy); else passed++;
        if (rsp_valid !== 1'b0) $display("FAIL midrst rsp_valid got %b want 0", rsp_valid); else passed++;
        if (req_ready !== 1'b1) $display("FAIL midrst req_ready got %b want 1", req_ready); else passed++;
        check_req(10'd500, "after_rst");
    endtask

    task automatic test_back_to_back;
        logic [9:0] a, b;
        logic [5:0] ca, cb;
        logic ea, eb, na, nb;
        int la, lb, w;
        a = 10'd56;
        b = 10'd1017;
        model(a, ca, ea, na, la);
        model(b, cb, eb, nb, lb);
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_size = a;
        @(posedge clk); #1;
        req_size = b;
        w = 0;
        while (!rsp_valid && w < 200) begin
            @(posedge clk); #1;
            w++;
        end
        total += 3;
        if (rsp_code !== ca || rsp_exact !== ea || rsp_none !== na)
            $display("FAIL b2b first got %0d/%b/%b want %0d/%b/%b", rsp_code, rsp_exact, rsp_none, ca, ea, na);
        else passed++;
        if (w != la) $display("FAIL b2b first latency got %0d want %0d", w, la); else passed++;
        @(posedge clk); #1;
        if (req_ready !== 1'b1) $display("FAIL b2b idle req_ready got %b want 1", req_ready); else passed++;
        @(posedge clk); #1;
        req_valid = 1'b0;
        total += 3;
        if (busy !== 1'b1) $display("FAIL b2b second_accept busy got %b want 1", busy); else passed++;
        w = 0;
        while (!rsp_valid && w < 200) begin
            @(posedge clk); #1;
            w++;
        end
        if (rsp_code !== cb || rsp_exact !== eb || rsp_none !== nb)
            $display("FAIL b2b second got %0d/%b/%b want %0d/%b/%b", rsp_code, rsp_exact, rsp_none, cb, eb, nb);
        else passed++;
        if (w != lb) $display("FAIL b2b second latency got %0d want %0d", w, lb); else passed++;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    initial begin
        test_reset;
        test_exact_all;
        test_bounds;
        test_random;
        test_backpressure;
        test_reset_mid;
        test_back_to_back;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/tamanho_codificador.md
Name: tamanho_codificador

Overview:
- Inverse of the square-size decode: takes a requested 10-bit square size and returns the 6-bit size code whose table size matches it exactly. If no exact match exists, returns the code of the largest table size not exceeding the request.
- Searches the 64-entry square-size table sequentially, one entry per clock.
- Sits between the size-request source (UI/control) and the logic that stores and forwards 6-bit size codes.
- Uses a valid/ready handshake on both request and response sides.

Parameters:
- SIZE_W, 10, width of the requested/table size value.
- CODE_W, 6, width of the size code; table depth = 2**CODE_W.
- EARLY_EXIT, 1, 1 = stop the scan at the first exact match; 0 = always scan all entries.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_size  in  SIZE_W  requested square size.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_code  out  CODE_W  resulting size code.
- rsp_exact  out  1  1 = table entry equals the request exactly.
- rsp_none  out  1  1 = every table entry is greater than the request; rsp_code = 0.
- busy  out  1  scan in progress.

Behaviour:
- Reset: one clock with synchronous active-high reset.
  - Outputs after reset: req_ready=1, rsp_valid=0, rsp_code=0, rsp_exact=0, rsp_none=0, busy=0.
  - Reset mid-scan or mid-response aborts the scan and drops the response with no further output.
- States:
  - IDLE: req_ready=1. When req_valid=1, latch req_size, set idx=0, best_size=0, best_code=0, found=0, then go to SCAN.
  - SCAN: busy=1, req_ready=0. Each cycle read entry = SIZE_TABLE[idx].
    - entry==req: record code=idx, exact=1.
    - entry<req and (found==0 or entry>best_size): record as best, found=1.
    - Ties keep the lowest code (strict compare).
    - Go to DONE when idx==63, or on an exact hit if EARLY_EXIT=1. Otherwise idx++.
  - DONE: rsp_valid=1 with outputs held stable. When rsp_ready=1, go to IDLE.
    - req_ready stays 0 until the transfer completes (no request overlap).
- Latency, request accept edge to rsp_valid:
  - exact hit at code k with EARLY_EXIT=1: k+2 cycles.
  - all other cases: 65 cycles.
- rsp_exact=1 forces rsp_none=0. When found=0 and no exact hit: rsp_none=1, rsp_code=0.
- All compares are unsigned, SIZE_W bits. There are no arithmetic widths beyond the compares.
- req_size is sampled only on the accept edge; changing it during SCAN has no effect.
- Holding rsp_ready=1 in IDLE or SCAN has no effect.
- The table is not assumed monotonic: the scan must be linear; binary search is forbidden.

Decomposition:
- Shared package `tamanho_pkg`:
  - SIZE_W, CODE_W.
  - Canonical SIZE_TABLE[0:63] of SIZE_W-bit sizes, the single source of truth also used by the code-to-size decode path.
  - State encoding IDLE/SCAN/DONE.
- One natural sub-module, `tamanho_tabela`: combinational idx→size ROM reading SIZE_TABLE, reusable by the decode path.
- The FSM, best-tracking registers and handshake stay in the top module.

Test Plan:
- Reset in IDLE, then every code k=0..63: request SIZE_TABLE[k] → rsp_exact=1, rsp_none=0; rsp_code = lowest code with that size; latency = k+2 with EARLY_EXIT=1 and 65 with EARLY_EXIT=0.
- Request 10'd1023 (no exact entry) → rsp_exact=0, rsp_none=0, rsp_code = argmax of SIZE_TABLE (lowest index on tie), latency 65.
- Request strictly below min(SIZE_TABLE) (10'd0 if table min>0) → rsp_none=1, rsp_code=0, rsp_exact=0.
- Backpressure: hold rsp_ready=0 for 20 cycles after rsp_valid → outputs stable, req_ready=0, a second req_valid pulse is ignored. Then rsp_ready=1 → IDLE next cycle, req_ready=1.
- Assert rst at scan cycle 10 → next cycle busy=0, rsp_valid=0, req_ready=1. A fresh request then completes correctly.
- Back-to-back: req_valid held high with two different sizes; rsp_ready tied high → two correct responses, the second request accepted the cycle after the first transfer.
